// File: rtl/dac_feedback_writer_if.sv
// Bus between the PI controller stage and the DAC feedback writer.
// Ports: sample input (data_in/data_in_valid), slew controls, serial DAC pins, status outputs.
// master = controller/bench side, slave = writer side.
interface dac_feedback_writer_if #(
  parameter int DATA_BITSIZE = 16
);
  logic [DATA_BITSIZE-1:0] data_in;
  logic                    data_in_valid;
  logic                    slew_enable;
  logic [DATA_BITSIZE-1:0] slew_step;
  logic                    dac_sclk;
  logic                    dac_sync_n;
  logic                    dac_sdin;
  logic                    busy;
  logic [DATA_BITSIZE-1:0] data_out;
  logic                    data_out_valid;
  logic [15:0]             dropped_count;

  modport master (
    output data_in, data_in_valid, slew_enable, slew_step,
    input  dac_sclk, dac_sync_n, dac_sdin, busy, data_out, data_out_valid, dropped_count
  );

  modport slave (
    input  data_in, data_in_valid, slew_enable, slew_step,
    output dac_sclk, dac_sync_n, dac_sdin, busy, data_out, data_out_valid, dropped_count
  );
endinterface

// File: rtl/dac_feedback_writer.sv
// Slew-limited serial DAC writer: sends {DAC_COMMAND, code} as a 24-bit frame per feedback sample.
// Latency: accepted IDLE sample -> data_out_valid in 2+48*SCLK_DIV cycles; busy until SYNC_GAP ends.
// No backpressure: samples arriving while busy land in a one-entry pending slot, newest wins, overwrites counted.
// Ports: clk, reset (sync, active-high), bus (slave modport: sample in, slew controls, DAC pins, status).
module dac_feedback_writer #(
  parameter int         DATA_BITSIZE  = 16,
  parameter int         SCLK_DIV      = 4,
  parameter logic [7:0] DAC_COMMAND   = 8'h30,
  parameter int         OFFSET_BINARY = 1,
  parameter int         SYNC_GAP      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dac_feedback_writer_if.slave bus
);
  localparam int          W        = DATA_BITSIZE;
  localparam int          GAP_CYC  = (SYNC_GAP < 1) ? 1 : SYNC_GAP;
  localparam logic [7:0]  DIV_LAST = 8'(SCLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t        state_q;
  logic [W-1:0]  target_q, pend_q, new_q, data_out_q;
  logic          pend_vld_q;
  logic [15:0]   dropped_q;
  logic [23:0]   shreg_q;
  logic [4:0]    bit_q;
  logic [7:0]    div_q;
  logic          high_q;
  logic [15:0]   gap_q;
  logic          sclk_q, sync_n_q, sdin_q, busy_q, dv_q;

  logic signed [W:0] delta_d, step_d, clamp_d;
  logic [W-1:0]      new_d, code_d;
  logic [23:0]       frame_d;

  // Delta is taken one bit wider so a full-scale swing (e.g. 7FFF -> 8000) cannot wrap.
  // The clamped delta always lies between 0 and the true delta, so the sum fits in W bits.
  always_comb begin
    delta_d = $signed({target_q[W-1], target_q}) - $signed({data_out_q[W-1], data_out_q});
    step_d  = $signed({1'b0, bus.slew_step});
    clamp_d = delta_d;
    if (bus.slew_enable) begin
      if (delta_d > step_d)       clamp_d = step_d;
      else if (delta_d < -step_d) clamp_d = -step_d;
    end
    new_d  = W'({data_out_q[W-1], data_out_q} + clamp_d);
    code_d = new_d;
    if (OFFSET_BINARY != 0) code_d[W-1] = ~new_d[W-1];
    // Top 16 bits of {code, zeros}: narrow words are right-padded with zeros.
    frame_d = {DAC_COMMAND, 16'({code_d, 16'h0000} >> W)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      new_q      <= '0;
      data_out_q <= '0;
      dropped_q  <= '0;
      shreg_q    <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      high_q     <= 1'b0;
      gap_q      <= '0;
      sclk_q     <= 1'b1;
      sync_n_q   <= 1'b1;
      sdin_q     <= 1'b0;
      busy_q     <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      dv_q <= 1'b0;

      if (bus.data_in_valid && state_q != S_IDLE) begin
        pend_q     <= bus.data_in;
        pend_vld_q <= 1'b1;
        if (pend_vld_q && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (pend_vld_q) begin
            // Older pending sample goes first; a same-cycle sample takes its slot.
            target_q   <= pend_q;
            pend_vld_q <= bus.data_in_valid;
            if (bus.data_in_valid) pend_q <= bus.data_in;
            state_q    <= S_LOAD;
            busy_q     <= 1'b1;
          end else if (bus.data_in_valid) begin
            target_q <= bus.data_in;
            state_q  <= S_LOAD;
            busy_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          new_q    <= new_d;
          sdin_q   <= frame_d[23];
          shreg_q  <= {frame_d[22:0], 1'b0};
          sclk_q   <= 1'b1;
          sync_n_q <= 1'b0;
          div_q    <= '0;
          high_q   <= 1'b1;
          bit_q    <= '0;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 8'd1;
          end else begin
            div_q <= '0;
            if (high_q) begin
              high_q <= 1'b0;
              sclk_q <= 1'b0;
            end else if (bit_q == 5'd23) begin
              state_q    <= S_GAP;
              sync_n_q   <= 1'b1;
              sclk_q     <= 1'b1;
              sdin_q     <= 1'b0;
              data_out_q <= new_q;
              dv_q       <= 1'b1;
              gap_q      <= GAP_LAST;
            end else begin
              bit_q   <= bit_q + 5'd1;
              high_q  <= 1'b1;
              sclk_q  <= 1'b1;
              sdin_q  <= shreg_q[23];
              shreg_q <= {shreg_q[22:0], 1'b0};
            end
          end
        end
        S_GAP: begin
          if (gap_q == 16'd0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dac_sclk       = sclk_q;
  assign bus.dac_sync_n     = sync_n_q;
  assign bus.dac_sdin       = sdin_q;
  assign bus.busy           = busy_q;
  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = dv_q;
  assign bus.dropped_count  = dropped_q;
endmodule

// File: tb/tb_dac_feedback_writer.sv
// Testbench for dac_feedback_writer: scenario tasks plus randomized frames against an arithmetic model.
// A negedge monitor reassembles serial frames from the DAC pins.
// Summary line reports total checks and errors.
module tb_dac_feedback_writer;
  localparam int W = 16;
  localparam int D = 4;
  localparam int G = 4;
  localparam int LAT = 2 + 48 * D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dac_feedback_writer_if #(.DATA_BITSIZE(W)) bus ();

  dac_feedback_writer #(
    .DATA_BITSIZE(W), .SCLK_DIV(D), .DAC_COMMAND(8'h30), .OFFSET_BINARY(1), .SYNC_GAP(G)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int model_out = 0;

  // Frame monitor
  logic        prev_sclk = 1'b1;
  logic        prev_sync = 1'b1;
  logic [23:0] cap = '0;
  logic [23:0] last_frame = '0;
  int nbits = 0, low_len = 0, last_bits = 0, last_low = 0;
  int frame_cnt = 0, sdin_bad = 0, dv_cnt = 0;

  always @(negedge clk) begin
    if (bus.dac_sync_n === 1'b1 && bus.dac_sdin !== 1'b0) sdin_bad++;
    if (bus.dac_sync_n === 1'b0) begin
      if (prev_sync === 1'b1) begin cap = '0; nbits = 0; low_len = 0; end
      low_len++;
      if (prev_sclk === 1'b1 && bus.dac_sclk === 1'b0) begin
        cap = {cap[22:0], bus.dac_sdin};
        nbits++;
      end
    end else if (prev_sync === 1'b0) begin
      last_frame = cap; last_bits = nbits; last_low = low_len; frame_cnt++;
    end
    if (bus.data_out_valid === 1'b1) dv_cnt++;
    prev_sclk = bus.dac_sclk;
    prev_sync = bus.dac_sync_n;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: move toward the target by at most step when slew limiting is on.
  function automatic int ref_next(int prev, int tgt, bit en, int step);
    int d;
    d = tgt - prev;
    if (en) begin
      if (d > step) d = step;
      if (d < -step) d = -step;
    end
    return prev + d;
  endfunction

  function automatic logic [23:0] ref_frame(int v);
    logic [15:0] c;
    c = 16'(v) ^ 16'h8000;
    return {8'h30, c};
  endfunction

  function automatic int s2i(logic [15:0] x);
    return int'($signed(x));
  endfunction

  task automatic do_reset();
    bus.data_in_valid = 1'b0;
    bus.data_in = '0;
    bus.slew_enable = 1'b0;
    bus.slew_step = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_out = 0;
  endtask

  task automatic send(input logic [15:0] v);
    @(posedge clk); #1;
    bus.data_in = v; bus.data_in_valid = 1'b1;
    @(posedge clk); #1;
    bus.data_in_valid = 1'b0;
  endtask

  task automatic wait_dv(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.data_out_valid === 1'b1) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_quiet(output bit ok);
    int run;
    run = 0; ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b0) run++; else run = 0;
      if (run >= 3) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.dac_sync_n !== 1'b1) begin errors++; $display("FAIL reset_sync_n got %b want 1", bus.dac_sync_n); end
    checks++; if (bus.dac_sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b want 1", bus.dac_sclk); end
    checks++; if (bus.dac_sdin !== 1'b0) begin errors++; $display("FAIL reset_sdin got %b want 0", bus.dac_sdin); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out got %h want 0000", bus.data_out); end
    checks++; if (bus.data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", bus.data_out_valid); end
    checks++; if (bus.dropped_count !== 16'h0) begin errors++; $display("FAIL reset_dropped got %h want 0000", bus.dropped_count); end
  endtask

  task automatic test_basic();
    int dv_cyc, busy_cnt, dv0, sb0;
    logic [15:0] dout;
    do_reset();
    dv_cyc = -1; busy_cnt = 0; dout = '0; dv0 = dv_cnt; sb0 = sdin_bad;
    @(posedge clk); #1;
    bus.data_in = 16'h1234; bus.data_in_valid = 1'b1;
    for (int cyc = 1; cyc <= LAT + G + 20; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) bus.data_in_valid = 1'b0;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.data_out_valid === 1'b1 && dv_cyc < 0) begin dv_cyc = cyc; dout = bus.data_out; end
    end
    checks++; if (dv_cyc != LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", dv_cyc, LAT); end
    checks++; if (dout !== 16'h1234) begin errors++; $display("FAIL basic_data_out got %h want 1234", dout); end
    checks++; if (last_frame !== 24'h309234) begin errors++; $display("FAIL basic_frame got %h want 309234", last_frame); end
    checks++; if (last_bits != 24) begin errors++; $display("FAIL basic_bits got %0d want 24", last_bits); end
    checks++; if (last_low != 48 * D) begin errors++; $display("FAIL basic_sync_low got %0d want %0d", last_low, 48 * D); end
    checks++; if (busy_cnt != LAT - 1 + G) begin errors++; $display("FAIL basic_busy_len got %0d want %0d", busy_cnt, LAT - 1 + G); end
    checks++; if (dv_cnt - dv0 != 1) begin errors++; $display("FAIL basic_dv_pulses got %0d want 1", dv_cnt - dv0); end
    checks++; if (sdin_bad != sb0) begin errors++; $display("FAIL basic_sdin_idle got %0d want %0d", sdin_bad, sb0); end
  endtask

  task automatic test_slew_ramp();
    bit got;
    int exp;
    do_reset();
    bus.slew_enable = 1'b1; bus.slew_step = 16'h0100;
    @(posedge clk); #1;
    bus.data_in = 16'h7FFF; bus.data_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_dv(LAT + G + 20, got);
      exp = ref_next(model_out, s2i(16'h7FFF), 1'b1, 32'h100);
      checks++; if (!got) begin errors++; $display("FAIL ramp_timeout step %0d got none want pulse", k); end
      checks++; if (bus.data_out !== 16'(exp)) begin errors++; $display("FAIL ramp_data_out step %0d got %h want %h", k, bus.data_out, 16'(exp)); end
      model_out = exp;
    end
    bus.data_in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    bit got, ok;
    do_reset();
    send(16'h7FFF);
    wait_dv(LAT + 20, got);
    checks++; if (!got || bus.data_out !== 16'h7FFF) begin errors++; $display("FAIL wrap_first got %h valid %b want 7fff", bus.data_out, got); end
    @(negedge clk); #1;
    checks++; if (last_frame !== 24'h30FFFF) begin errors++; $display("FAIL wrap_first_frame got %h want 30ffff", last_frame); end
    wait_quiet(ok);
    send(16'h8000);
    wait_dv(LAT + 20, got);
    checks++; if (!got || bus.data_out !== 16'h8000) begin errors++; $display("FAIL wrap_data_out got %h valid %b want 8000", bus.data_out, got); end
    @(negedge clk); #1;
    checks++; if (last_frame !== 24'h300000) begin errors++; $display("FAIL wrap_frame got %h want 300000", last_frame); end
  endtask

  task automatic test_pending();
    bit got, ok;
    int f0, d0;
    do_reset();
    f0 = frame_cnt; d0 = dv_cnt;
    send(16'h1111);
    repeat (10) @(posedge clk); #1;
    send(16'h2222);
    repeat (5) @(posedge clk); #1;
    send(16'h3333);
    repeat (5) @(posedge clk); #1;
    send(16'h4444);
    wait_dv(LAT + 20, got);
    checks++; if (!got || bus.data_out !== 16'h1111) begin errors++; $display("FAIL pend_first got %h valid %b want 1111", bus.data_out, got); end
    wait_dv(LAT + G + 20, got);
    checks++; if (!got || bus.data_out !== 16'h4444) begin errors++; $display("FAIL pend_newest got %h valid %b want 4444", bus.data_out, got); end
    @(negedge clk); #1;
    checks++; if (last_frame !== 24'h30C444) begin errors++; $display("FAIL pend_frame got %h want 30c444", last_frame); end
    checks++; if (bus.dropped_count !== 16'd2) begin errors++; $display("FAIL pend_dropped got %0d want 2", bus.dropped_count); end
    wait_quiet(ok);
    checks++; if (!ok || frame_cnt - f0 != 2 || dv_cnt - d0 != 2) begin errors++; $display("FAIL pend_frame_count got %0d/%0d want 2/2", frame_cnt - f0, dv_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    bit got;
    do_reset();
    send(16'h0AAA);
    repeat (20) @(posedge clk); #1;
    send(16'h0BBB);
    wait_dv(LAT + 20, got);
    checks++; if (!got || bus.data_out !== 16'h0AAA) begin errors++; $display("FAIL b2b_first got %h valid %b want 0aaa", bus.data_out, got); end
    // Present a new sample in the first IDLE cycle, when the pending one is also waiting.
    repeat (G) @(posedge clk); #1;
    bus.data_in = 16'h0CCC; bus.data_in_valid = 1'b1;
    @(posedge clk); #1;
    bus.data_in_valid = 1'b0;
    wait_dv(LAT + 20, got);
    checks++; if (!got || bus.data_out !== 16'h0BBB) begin errors++; $display("FAIL b2b_pending_first got %h valid %b want 0bbb", bus.data_out, got); end
    wait_dv(LAT + G + 20, got);
    checks++; if (!got || bus.data_out !== 16'h0CCC) begin errors++; $display("FAIL b2b_second got %h valid %b want 0ccc", bus.data_out, got); end
    checks++; if (bus.dropped_count !== 16'd0) begin errors++; $display("FAIL b2b_dropped got %0d want 0", bus.dropped_count); end
  endtask

  task automatic test_reset_mid();
    bit got, ok, hit;
    int d0;
    do_reset();
    send(16'h2345);
    wait_dv(LAT + 20, got);
    wait_quiet(ok);
    send(16'h6789);
    hit = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(posedge clk); #1;
      if (bus.dac_sync_n === 1'b0 && nbits == 10) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL midrst_reach_bit10 got none want bit 10"); end
    reset = 1'b1;
    d0 = dv_cnt;
    @(posedge clk); #1;
    checks++; if (bus.dac_sync_n !== 1'b1 || bus.dac_sclk !== 1'b1 || bus.dac_sdin !== 1'b0) begin errors++; $display("FAIL midrst_pins got sync_n %b sclk %b sdin %b want 1 1 0", bus.dac_sync_n, bus.dac_sclk, bus.dac_sdin); end
    checks++; if (bus.busy !== 1'b0 || bus.data_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_status got busy %b dv %b want 0 0", bus.busy, bus.data_out_valid); end
    checks++; if (bus.data_out !== 16'h0 || bus.dropped_count !== 16'h0) begin errors++; $display("FAIL midrst_regs got data_out %h dropped %h want 0000 0000", bus.data_out, bus.dropped_count); end
    reset = 1'b0;
    repeat (LAT + 20) @(posedge clk); #1;
    checks++; if (dv_cnt != d0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_no_resume got pulses %0d busy %b want 0 0", dv_cnt - d0, bus.busy); end
  endtask

  task automatic test_hold();
    bit got, ok;
    do_reset();
    send(16'h0050);
    wait_dv(LAT + 20, got);
    wait_quiet(ok);
    bus.slew_enable = 1'b1; bus.slew_step = 16'h0000;
    send(16'h1000);
    wait_dv(LAT + 20, got);
    checks++; if (!got || bus.data_out !== 16'h0050) begin errors++; $display("FAIL hold_data_out got %h valid %b want 0050", bus.data_out, got); end
    @(negedge clk); #1;
    checks++; if (last_frame !== 24'h308050) begin errors++; $display("FAIL hold_frame got %h want 308050", last_frame); end
  endtask

  task automatic test_random();
    bit got, ok, en;
    int step, exp;
    logic [15:0] tgt;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      tgt  = 16'($urandom);
      en   = 1'($urandom_range(0, 1));
      step = ($urandom_range(0, 3) == 0) ? 0 : (int'($urandom & 32'hFFFF) >> $urandom_range(0, 15));
      bus.slew_enable = en; bus.slew_step = 16'(step);
      send(tgt);
      wait_dv(LAT + 20, got);
      exp = ref_next(model_out, s2i(tgt), en, step);
      checks++; if (!got || bus.data_out !== 16'(exp)) begin errors++; $display("FAIL rand_data_out iter %0d got %h valid %b want %h", n, bus.data_out, got, 16'(exp)); end
      @(negedge clk); #1;
      checks++; if (last_frame !== ref_frame(exp)) begin errors++; $display("FAIL rand_frame iter %0d got %h want %h", n, last_frame, ref_frame(exp)); end
      model_out = exp;
      wait_quiet(ok);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slew_ramp();
    test_wrap();
    test_pending();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
